// File: rtl/rectangle_stream_pkg.sv
// Shared types and constants for the rectangle point streamer.
// Filled mode exists only when RECTANGLE_STREAM_FILL_EN is defined.
package rectangle_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_OUTLINE = 1'b0;
    localparam logic MODE_FILL    = 1'b1;

endpackage

// File: rtl/raster_counter.sv
// Row/column scan for one rectangle. In outline mode, interior rows jump
// straight from the first column to the last column.
module raster_counter
    import rectangle_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] height_i,
    input  logic [WIDTH-1:0] width_i,
    input  logic             mode_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] row_o,
    output logic [WIDTH-1:0] col_o,
    output logic             last_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] row_q, row_d;
    logic [WIDTH-1:0] col_q, col_d;
    logic [WIDTH-1:0] row_last_q;
    logic [WIDTH-1:0] col_last_q;
    logic             mode_q;
    logic             interior_row;

    assign interior_row = (row_q != '0) && (row_q != row_last_q);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (advance_i) begin
            // End-of-row test comes first so a single-column rectangle never skips.
            if (col_q == col_last_q) begin
                col_d = '0;
                row_d = row_q + ONE;
            end else if (mode_q == MODE_OUTLINE && interior_row && col_q == '0) begin
                col_d = col_last_q;
            end else begin
                col_d = col_q + ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q      <= '0;
            col_q      <= '0;
            row_last_q <= '0;
            col_last_q <= '0;
            mode_q     <= MODE_OUTLINE;
        end else if (load_i) begin
            row_q      <= '0;
            col_q      <= '0;
            row_last_q <= height_i - ONE;
            col_last_q <= width_i - ONE;
            mode_q     <= mode_i;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == row_last_q) && (col_q == col_last_q);

endmodule

// File: rtl/rectangle_stream.sv
// Streams the points of a rectangle (outline, or filled when
// RECTANGLE_STREAM_FILL_EN is defined) over a valid/ready handshake.
module rectangle_stream
    import rectangle_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic signed [WIDTH-1:0] s_x,
    input  logic signed [WIDTH-1:0] s_y,
    input  logic signed [WIDTH-1:0] height,
    input  logic signed [WIDTH-1:0] width,
    input  logic                    _mode,
    input  logic                    _ready,
    output logic signed [WIDTH-1:0] _out0,
    output logic signed [WIDTH-1:0] _out1,
    output logic                    _valid,
    output logic                    _done
);

    // Handshake: a point transfers on a rising edge where _valid and _ready
    // are both high; while _valid is high and _ready low the point holds.

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sx_q, sy_q;
    logic [WIDTH-1:0] row, col;
    logic             last;
    logic             advance;
    logic             dims_ok;
    logic             mode_eff;

`ifdef RECTANGLE_STREAM_FILL_EN
    assign mode_eff = _mode;
`else
    logic unused_mode;
    assign unused_mode = _mode;
    assign mode_eff    = MODE_OUTLINE;
`endif

    assign dims_ok = !height[WIDTH-1] && (height != '0) &&
                     !width[WIDTH-1]  && (width  != '0);
    assign advance = (state_q == ST_BUSY) && _ready;

    raster_counter #(.WIDTH(WIDTH)) u_raster (
        .clk_i     (_clock),
        .rst_i     (_reset),
        .load_i    (_start),
        .height_i  (height),
        .width_i   (width),
        .mode_i    (mode_eff),
        .advance_i (advance),
        .row_o     (row),
        .col_o     (col),
        .last_o    (last)
    );

    always_comb begin
        state_d = state_q;
        if (_start) begin
            state_d = dims_ok ? ST_BUSY : ST_DONE;
        end else begin
            case (state_q)
                ST_BUSY: if (advance && last) state_d = ST_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_q <= ST_IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
        end else begin
            state_q <= state_d;
            if (_start) begin
                sx_q <= s_x;
                sy_q <= s_y;
            end
        end
    end

    // Coordinates wrap modulo 2^WIDTH.
    assign _out0  = sx_q + row;
    assign _out1  = sy_q + col;
    assign _valid = (state_q == ST_BUSY);
    assign _done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_rectangle_stream.sv
// Directed bench for rectangle_stream with a point scoreboard.
module tb_rectangle_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, mode, ready;
    logic signed [31:0] sx, sy, h, w;
    logic signed [31:0] out0, out1;
    logic               valid, done;

    logic              start8, mode8, ready8;
    logic signed [7:0] sx8, sy8, h8, w8;
    logic signed [7:0] o0_8, o1_8;
    logic              valid8, done8;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int last_acc_cyc = -10;
    logic [63:0] exp_q[$];
    logic [7:0]  exp8_q[$];

    rectangle_stream #(.WIDTH(32)) dut (
        ._clock(clk), ._reset(rst), ._start(start), .s_x(sx), .s_y(sy),
        .height(h), .width(w), ._mode(mode), ._ready(ready),
        ._out0(out0), ._out1(out1), ._valid(valid), ._done(done)
    );

    rectangle_stream #(.WIDTH(8)) dut8 (
        ._clock(clk), ._reset(rst), ._start(start8), .s_x(sx8), .s_y(sy8),
        .height(h8), .width(w8), ._mode(mode8), ._ready(ready8),
        ._out0(o0_8), ._out1(o1_8), ._valid(valid8), ._done(done8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int push_rect(input logic signed [31:0] a, input logic signed [31:0] b,
                                     input int hh, input int ww, input logic fill);
        int n = 0;
        for (int i = 0; i < hh; i++) begin
            for (int j = 0; j < ww; j++) begin
                if (fill || i == 0 || i == hh - 1 || j == 0 || j == ww - 1) begin
                    exp_q.push_back({a + i, b + j});
                    n++;
                end
            end
        end
        return n;
    endfunction

    task automatic start_rect(input logic signed [31:0] a, input logic signed [31:0] b,
                              input logic signed [31:0] hh, input logic signed [31:0] ww,
                              input logic m);
        @(posedge clk); #1;
        sx = a; sy = b; h = hh; w = ww; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles with _done low, from the first cycle after _start.
    task automatic wait_done(input string tag, input int npts, output int n);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (done === 1'b1) break;
            n++;
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_valid_low"}, valid, 1'b0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        if (npts > 0) check({tag, "_done_latency"}, cyc, last_acc_cyc + 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1 && ready === 1'b1) begin
            acc_cnt++;
            last_acc_cyc = cyc;
            check("point_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("point", {out0, out1}, exp_q.pop_front());
        end
    end

    initial begin
        int n, npts, k, base;
        logic fill_exp;
`ifdef RECTANGLE_STREAM_FILL_EN
        fill_exp = 1'b1;
`else
        fill_exp = 1'b0;
`endif
        rst = 1'b1; start = 1'b0; mode = 1'b0; ready = 1'b1;
        sx = 0; sy = 0; h = 0; w = 0;
        start8 = 1'b0; mode8 = 1'b0; ready8 = 1'b1;
        sx8 = 0; sy8 = 0; h8 = 0; w8 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out", {out0, out1}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Outline 3x4
        npts = push_rect(10, 20, 3, 4, 1'b0);
        start_rect(10, 20, 3, 4, 1'b0);
        @(negedge clk);
        check("first_point_valid", valid, 1'b1);
        wait_done("outline", npts, n);
        check("outline_count", n + 1, 10);
        repeat (2) @(negedge clk);
        check("done_hold", done, 1'b1);

        // Filled request; outline when the feature is compiled out
        npts = push_rect(10, 20, 3, 4, fill_exp);
        start_rect(10, 20, 3, 4, 1'b1);
        wait_done("mode1", npts, n);
        check("mode1_count", n, fill_exp ? 12 : 10);

        // Backpressure on (10,21)
        npts = push_rect(10, 20, 3, 4, 1'b0);
        start_rect(10, 20, 3, 4, 1'b0);
        @(posedge clk); #1;
        ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold", {valid, out0, out1}, {1'b1, 32'sd10, 32'sd21});
        end
        @(posedge clk); #1;
        ready = 1'b1;
        wait_done("bp", npts, n);
        check("bp_rest", n, 9);

        // Degenerate dimensions
        start_rect(5, 5, 0, 5, 1'b0);
        wait_done("h0", 0, n);
        check("h0_latency", n, 0);
        start_rect(5, 5, 3, -2, 1'b0);
        wait_done("wneg", 0, n);
        check("wneg_latency", n, 0);
        npts = push_rect(7, -3, 1, 3, 1'b0);
        start_rect(7, -3, 1, 3, 1'b0);
        wait_done("row1", npts, n);
        check("row1_count", n, 3);
        npts = push_rect(-2, 4, 4, 1, 1'b0);
        start_rect(-2, 4, 4, 1, 1'b0);
        wait_done("col1", npts, n);
        check("col1_count", n, 4);

        // Reset after the 4th point
        base = acc_cnt;
        npts = push_rect(10, 20, 3, 4, 1'b0);
        start_rect(10, 20, 3, 4, 1'b0);
        k = 0;
        while (acc_cnt < base + 4 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        check("reset_reach4", acc_cnt >= base + 4, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1; ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; ready = 1'b1;
        @(negedge clk);
        check("midrst_state", {valid, done, out0, out1}, {2'b00, 64'd0});
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check("midrst_quiet", {valid, done}, 2'b00);
        end
        npts = push_rect(10, 20, 3, 4, 1'b0);
        start_rect(10, 20, 3, 4, 1'b0);
        wait_done("restart", npts, n);
        check("restart_count", n, 10);

        // Reset wins over a simultaneous start
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; sx = 1; sy = 1; h = 2; w = 2;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_prio", {valid, done}, 2'b00);

        // 8-bit column wrap
        exp8_q = '{8'h7E, 8'h7F, 8'h80, 8'h81};
        @(posedge clk); #1;
        sx8 = 0; sy8 = 8'sd126; h8 = 8'sd1; w8 = 8'sd4; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("wrap_point", {valid8, o0_8, o1_8}, {1'b1, 8'd0, exp8_q.pop_front()});
        end
        @(negedge clk);
        check("wrap_done", {valid8, done8}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rectangle_stream.md
RECTANGLE_STREAM -- requirements
Module: rectangle_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32, signed width of every coordinate and dimension port.
REQ-002 SHALL have port _clock  input  1  the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port _reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port _start  input  1  one-cycle request to latch inputs and begin a new rectangle.
REQ-005 SHALL have port s_x  input  WIDTH  signed start row.
REQ-006 SHALL have port s_y  input  WIDTH  signed start column.
REQ-007 SHALL have port height  input  WIDTH  signed row count.
REQ-008 SHALL have port width  input  WIDTH  signed column count.
REQ-009 SHALL have port _mode  input  1  0 = outline, 1 = filled.
REQ-010 SHALL have port _ready  input  1  consumer accepts the current point.
REQ-011 SHALL have port _out0  output  WIDTH  signed row coordinate of the current point.
REQ-012 SHALL have port _out1  output  WIDTH  signed column coordinate of the current point.
REQ-013 SHALL have port _valid  output  1  _out0/_out1 hold a point.
REQ-014 SHALL have port _done  output  1  the rectangle is fully emitted.

Function
REQ-015 SHALL implement states IDLE, BUSY and DONE.
REQ-016 SHALL latch s_x, s_y, height, width and _mode on any cycle with _start=1, in any state, discarding any point in flight.
REQ-017 SHALL, when the latched height and width are both >0, enter BUSY and present point (s_x, s_y) with _valid=1 in the cycle after _start.
REQ-018 SHALL, when either dimension is <=0, enter DONE in the cycle after _start with _valid=0 and emit no points.
REQ-019 SHALL, in outline mode, emit each perimeter point exactly once in raster order (row i ascending, column j ascending), with no duplicated corners.
REQ-020 SHALL treat (s_x+i, s_y+j) as a perimeter point when i is 0 or height-1, or j is 0 or width-1.
REQ-021 SHALL, on interior rows in outline mode, step from j=0 directly to j=width-1 with no bubble cycles.
REQ-022 SHALL, in filled mode, emit all height*width points in raster order.
REQ-023 SHALL advance to the next point only on a cycle with _valid=1 and _ready=1; otherwise _out0, _out1 and _valid SHALL hold stable.
REQ-024 SHALL sustain one point per cycle while _ready=1.
REQ-025 SHALL enter DONE in the cycle after the last point is accepted, setting _valid=0 and _done=1.
REQ-026 SHALL hold _done=1 until the next _start or _reset, and SHALL drive _done=0 in every other state.
REQ-027 SHALL compute coordinates as WIDTH-bit two's-complement sums that wrap silently.
REQ-028 SHALL produce height points in a single-column rectangle (width=1) and width points in a single-row rectangle (height=1), each point emitted once.

Reset
REQ-029 SHALL, when _reset=1, enter IDLE next cycle with _valid=0, _done=0, _out0=0, _out1=0 and internal counters cleared.
REQ-030 SHALL give _reset priority over a simultaneous _start.
REQ-031 SHALL, after _reset mid-operation, emit nothing until a new _start.

Configuration
REQ-032 SHALL compile in filled mode only when macro RECTANGLE_STREAM_FILL_EN is defined.
REQ-033 SHALL, when RECTANGLE_STREAM_FILL_EN is undefined, keep the _mode port, ignore its value and always use outline mode.

Structure
REQ-034 SHALL define the state enum typedef and the MODE_OUTLINE/MODE_FILL constants in shared package rectangle_stream_pkg.
REQ-035 SHALL implement the row/column scan, including the interior-row skip, in a single sub-module raster_counter.

Verification
REQ-036 SHALL check outline, s_x=10, s_y=20, height=3, width=4, _ready=1 -> 10 points (10,20..23), (11,20), (11,23), (12,20..23); _done=1 the cycle after the last point.
REQ-037 SHALL check the same inputs with _mode=1 and the macro defined -> 12 points in raster order; with the macro undefined -> the 10 outline points.
REQ-038 SHALL check backpressure: _ready=0 for 3 cycles while (10,21) is presented -> (10,21) held stable, then (10,22) follows, with no loss or duplication.
REQ-039 SHALL check height=0, width=5 -> no _valid, _done=1 one cycle after _start; and height=1, width=3 -> exactly 3 points.
REQ-040 SHALL check _reset asserted after the 4th point -> _valid=0 and _done=0 next cycle; a subsequent _start restarts from (s_x, s_y).
REQ-041 SHALL check WIDTH=8, s_y=126, width=4, height=1 -> columns 126, 127, -128, -127.
